// File: rtl/dcache_refill_ctrl_if.sv
// Line interface between the data-cache refill controller, the cache miss
// port and the on-chip memory. The controller takes the master modport; the
// cache/OCM side takes the slave modport.
interface dcache_refill_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic [15:0]  req_fill_addr;
    logic         req_evict;
    logic [15:0]  req_evict_addr;
    logic [127:0] req_evict_data;
    logic [15:0]  req_evict_mask;
    logic         fill_done;
    logic         err;
    logic         mem_request;
    logic         mem_rwn;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_commit;
    logic [127:0] mem_write_data;
    logic         mem_finish;
    logic         mem_partial;
    logic         mem_replace;

    modport master (
        input  req_valid, req_fill_addr, req_evict, req_evict_addr,
               req_evict_data, req_evict_mask,
               mem_finish, mem_partial, mem_replace,
        output req_ready, fill_done, err,
               mem_request, mem_rwn, mem_addr, mem_commit, mem_write_data
    );

    modport slave (
        output req_valid, req_fill_addr, req_evict, req_evict_addr,
               req_evict_data, req_evict_mask,
               mem_finish, mem_partial, mem_replace,
        input  req_ready, fill_done, err,
               mem_request, mem_rwn, mem_addr, mem_commit, mem_write_data
    );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill controller: optional dirty-victim write-back followed by
// a line read, with partial/timeout retry from a shared budget and a sticky
// error once the budget is spent.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | ready for a miss; latches request fields on req_valid
//  WB_REQ  | one-cycle write request for the victim line
//  WB_WAIT | waiting for write completion (timer running)
//  RD_REQ  | one-cycle read request for the fill line
//  RD_WAIT | waiting for read completion with refill data (timer running)
//  DONE    | one-cycle fill_done pulse
//  ERR     | retry budget exhausted; held until reset
module dcache_refill_ctrl #(
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    dcache_refill_ctrl_if.master bus
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic [RTY_W-1:0]   rty_q;
    logic [15:0]        fill_addr_q;
    logic               mem_rwn_q;
    logic [15:0]        mem_addr_q;
    logic [15:0]        mem_commit_q;
    logic [127:0]       mem_data_q;
    logic               accept;
    logic               load_rd;
    logic               retry_take;
    logic               tmr_tc;

    // Timer down-counter reaches terminal count on the TIMEOUT-th WAIT cycle.
    assign tmr_tc = (tmr_q == '0);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state decode; a clean finish always wins over a same-cycle timeout.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        load_rd    = 1'b0;
        retry_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = bus.req_evict ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: state_d = WB_WAIT;
            WB_WAIT: begin
                if (bus.mem_finish && !bus.mem_partial) begin
                    load_rd = 1'b1;
                    state_d = RD_REQ;
                end else if (bus.mem_finish || tmr_tc) begin
                    if (rty_q < RTY_MAX) begin
                        retry_take = 1'b1;
                        state_d    = WB_REQ;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.mem_finish && !bus.mem_partial && bus.mem_replace) begin
                    state_d = DONE;
                end else if (bus.mem_finish || tmr_tc) begin
                    if (rty_q < RTY_MAX) begin
                        retry_take = 1'b1;
                        state_d    = RD_REQ;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Wait timer: loaded on each request cycle, counts down through WAIT.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                               tmr_q <= '0;
        else if (state_q == WB_REQ || state_q == RD_REQ) tmr_q <= TMR_LOAD;
        else if (!tmr_tc)                             tmr_q <= tmr_q - TMR_W'(1);
    end

    // Retry budget is shared by both phases of one miss.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)      rty_q <= '0;
        else if (accept)     rty_q <= '0;
        else if (retry_take) rty_q <= rty_q + RTY_W'(1);
    end

    // Transaction fields: victim goes straight to the bus registers so a
    // retry reissues it unchanged; the fill address waits for the read phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill_addr_q  <= '0;
            mem_rwn_q    <= 1'b1;
            mem_addr_q   <= '0;
            mem_commit_q <= '0;
            mem_data_q   <= '0;
        end else if (accept) begin
            fill_addr_q <= bus.req_fill_addr & 16'hFFF0;
            if (bus.req_evict) begin
                mem_rwn_q    <= 1'b0;
                mem_addr_q   <= bus.req_evict_addr & 16'hFFF0;
                mem_commit_q <= bus.req_evict_mask;
                mem_data_q   <= bus.req_evict_data;
            end else begin
                mem_rwn_q    <= 1'b1;
                mem_addr_q   <= bus.req_fill_addr & 16'hFFF0;
                mem_commit_q <= '0;
            end
        end else if (load_rd) begin
            mem_rwn_q    <= 1'b1;
            mem_addr_q   <= fill_addr_q;
            mem_commit_q <= '0;
        end
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.mem_request    = (state_q == WB_REQ) || (state_q == RD_REQ);
    assign bus.fill_done      = (state_q == DONE);
    assign bus.err            = (state_q == ERR);
    assign bus.mem_rwn        = mem_rwn_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_commit     = mem_commit_q;
    assign bus.mem_write_data = mem_data_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Bench for dcache_refill_ctrl: directed scenarios with literal expectations,
// then randomized misses/responses, all checked every cycle against an
// attempt-timeline model.
module tb_dcache_refill_ctrl;
    localparam int TIMEOUT   = 15;
    localparam int MAX_RETRY = 3;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    dcache_refill_ctrl_if bus ();

    dcache_refill_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a miss is a sequence of attempts, each a request on cycle
    // m_issue followed by a response window of TIMEOUT cycles.
    bit           m_act, m_err, m_wr;
    int           m_issue, m_done_at, m_retries;
    logic [15:0]  m_addr, m_commit, m_fill;
    logic [127:0] m_data;

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic a, input logic e);
        chk(name, 128'(a), 128'(e));
    endtask

    task automatic chk16(input string name, input logic [15:0] a, input logic [15:0] e);
        chk(name, 128'(a), 128'(e));
    endtask

    task automatic chki(input string name, input int a, input int e);
        chk(name, 128'(a), 128'(e));
    endtask

    task automatic model_reset();
        m_act = 0; m_err = 0; m_wr = 0;
        m_issue = -1; m_done_at = -1; m_retries = 0;
    endtask

    task automatic model_step();
        bit ok, fail;
        if (m_err) begin
            // sticky until reset
        end else if (!m_act) begin
            if (bus.req_valid) begin
                m_act = 1; m_done_at = -1; m_retries = 0; m_issue = cyc + 1;
                m_fill = bus.req_fill_addr & 16'hFFF0;
                if (bus.req_evict) begin
                    m_wr = 1; m_addr = bus.req_evict_addr & 16'hFFF0;
                    m_commit = bus.req_evict_mask; m_data = bus.req_evict_data;
                end else begin
                    m_wr = 0; m_addr = m_fill; m_commit = '0;
                end
            end
        end else if (m_done_at >= 0) begin
            if (cyc >= m_done_at) m_act = 0;
        end else if (cyc > m_issue) begin
            ok   = bus.mem_finish && !bus.mem_partial && (m_wr || bus.mem_replace);
            fail = bus.mem_finish ? !ok : ((cyc - m_issue) == TIMEOUT);
            if (ok) begin
                if (m_wr) begin
                    m_wr = 0; m_addr = m_fill; m_commit = '0; m_issue = cyc + 1;
                end else begin
                    m_done_at = cyc + 1;
                end
            end else if (fail) begin
                if (m_retries < MAX_RETRY) begin
                    m_retries++; m_issue = cyc + 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare();
        bit busy;
        busy = m_act && !m_err && (m_done_at < 0);
        chk1("req_ready", bus.req_ready, !m_act && !m_err);
        chk1("fill_done", bus.fill_done, m_act && !m_err && (cyc == m_done_at));
        chk1("err", bus.err, m_err);
        chk1("mem_request", bus.mem_request, busy && (cyc == m_issue));
        if (busy) begin
            chk1("mem_rwn", bus.mem_rwn, !m_wr);
            chk16("mem_addr", bus.mem_addr, m_addr);
            chk16("mem_commit", bus.mem_commit, m_commit);
            if (m_wr) chk("mem_write_data", bus.mem_write_data, m_data);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        compare();
    endtask

    task automatic clr_in();
        bus.req_valid   = 1'b0;
        bus.mem_finish  = 1'b0;
        bus.mem_partial = 1'b0;
        bus.mem_replace = 1'b0;
    endtask

    // Called at a negedge; reset takes effect mid-cycle, away from any edge.
    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk1("rst_req_ready", bus.req_ready, 1'b1);
        chk1("rst_mem_request", bus.mem_request, 1'b0);
        chk1("rst_mem_rwn", bus.mem_rwn, 1'b1);
        chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk16("rst_mem_commit", bus.mem_commit, 16'h0000);
        chk("rst_mem_write_data", bus.mem_write_data, 128'h0);
        chk1("rst_fill_done", bus.fill_done, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        clr_in();
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc = 0;
        compare();
    endtask

    task automatic clean_miss(input string tag);
        clr_in(); bus.req_valid = 1'b1; bus.req_fill_addr = 16'h1A37; bus.req_evict = 1'b0;
        tick();                                            // cycle 1
        bus.req_valid = 1'b0;
        chk1({tag, "_req"}, bus.mem_request, 1'b1);
        chk16({tag, "_addr"}, bus.mem_addr, 16'h1A30);
        chk1({tag, "_rwn"}, bus.mem_rwn, 1'b1);
        chk16({tag, "_commit"}, bus.mem_commit, 16'h0000);
        tick();                                            // cycle 2
        chk1({tag, "_req_single"}, bus.mem_request, 1'b0);
        bus.mem_finish = 1'b1; bus.mem_replace = 1'b1;
        tick();                                            // cycle 3
        clr_in();
        chk1({tag, "_done"}, bus.fill_done, 1'b1);
        chk1({tag, "_busy"}, bus.req_ready, 1'b0);
        tick();                                            // cycle 4
        chk1({tag, "_ready"}, bus.req_ready, 1'b1);
    endtask

    localparam logic [127:0] D = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    initial begin
        int c0, err_at, n_req;
        int req_at[$];
        bit dead;

        clr_in();
        bus.req_fill_addr = '0; bus.req_evict = 1'b0; bus.req_evict_addr = '0;
        bus.req_evict_data = '0; bus.req_evict_mask = '0;
        @(negedge sys_clk);
        do_reset();

        // Clean miss.
        clean_miss("clean");

        // Dirty miss: write-back then read.
        bus.req_valid = 1'b1; bus.req_evict = 1'b1; bus.req_evict_addr = 16'h0455;
        bus.req_evict_mask = 16'h00FF; bus.req_evict_data = D; bus.req_fill_addr = 16'h8000;
        tick();                                            // cycle 1
        bus.req_valid = 1'b0;
        chk1("dirty_wr_req", bus.mem_request, 1'b1);
        chk1("dirty_wr_rwn", bus.mem_rwn, 1'b0);
        chk16("dirty_wr_addr", bus.mem_addr, 16'h0450);
        chk16("dirty_wr_commit", bus.mem_commit, 16'h00FF);
        chk("dirty_wr_data", bus.mem_write_data, D);
        tick();                                            // cycle 2
        bus.mem_finish = 1'b1;
        tick();                                            // cycle 3
        clr_in();
        chk1("dirty_rd_req", bus.mem_request, 1'b1);
        chk1("dirty_rd_rwn", bus.mem_rwn, 1'b1);
        chk16("dirty_rd_addr", bus.mem_addr, 16'h8000);
        tick();                                            // cycle 4
        bus.mem_finish = 1'b1; bus.mem_replace = 1'b1;
        tick();                                            // cycle 5
        clr_in();
        chk1("dirty_done", bus.fill_done, 1'b1);
        tick();

        // Partial completion of the first write.
        bus.req_valid = 1'b1;
        tick();                                            // cycle 1
        bus.req_valid = 1'b0;
        tick();                                            // cycle 2
        bus.mem_finish = 1'b1; bus.mem_partial = 1'b1;
        tick();                                            // cycle 3
        clr_in();
        chk1("partial_reissue", bus.mem_request, 1'b1);
        chk1("partial_reissue_rwn", bus.mem_rwn, 1'b0);
        chk16("partial_reissue_addr", bus.mem_addr, 16'h0450);
        tick();                                            // cycle 4
        bus.mem_finish = 1'b1;
        tick();                                            // cycle 5
        clr_in();
        chk1("partial_rd_req", bus.mem_request, 1'b1);
        tick();                                            // cycle 6
        bus.mem_finish = 1'b1; bus.mem_replace = 1'b1;
        tick();                                            // cycle 7
        clr_in();
        chk1("partial_done", bus.fill_done, 1'b1);
        tick();

        // Finish on the last cycle of the window is accepted.
        bus.req_valid = 1'b1; bus.req_evict = 1'b0; bus.req_fill_addr = 16'h2345;
        tick();                                            // cycle 1
        bus.req_valid = 1'b0;
        n_req = 0;
        for (int k = 1; k <= 16; k++) begin
            if (bus.mem_request) n_req++;
            if (k == 16) begin bus.mem_finish = 1'b1; bus.mem_replace = 1'b1; end
            tick();
            clr_in();
        end
        chk1("edge_done", bus.fill_done, 1'b1);
        chki("edge_nreq", n_req, 1);
        tick();

        // Stray finish while idle.
        bus.mem_finish = 1'b1; bus.mem_replace = 1'b1;
        tick(); tick(); tick();
        clr_in();
        chk1("stray_ready", bus.req_ready, 1'b1);
        chk1("stray_req", bus.mem_request, 1'b0);

        // No response at all: budget exhaustion.
        c0 = cyc; err_at = -1;
        bus.req_valid = 1'b1; bus.req_fill_addr = 16'h3000;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (bus.mem_request) req_at.push_back(cyc - c0);
            if (bus.err && err_at < 0) err_at = cyc - c0;
            tick();
        end
        chki("tmo_nreq", req_at.size(), 4);
        for (int i = 0; i < req_at.size() && i < 4; i++) chki("tmo_req_cycle", req_at[i], 1 + 16 * i);
        chki("tmo_err_cycle", err_at, 65);
        chk1("tmo_err", bus.err, 1'b1);
        chk1("tmo_ready", bus.req_ready, 1'b0);
        bus.req_valid = 1'b1;
        tick(); tick();
        bus.req_valid = 1'b0;
        chk1("tmo_err_sticky", bus.err, 1'b1);
        do_reset();

        // Reset while waiting for read completion.
        bus.req_valid = 1'b1; bus.req_fill_addr = 16'h5550;
        tick(); bus.req_valid = 1'b0;
        tick(); tick();
        do_reset();
        bus.mem_finish = 1'b1; bus.mem_replace = 1'b1;
        tick(); tick();
        clr_in();
        chk1("rst_wait_no_done", bus.fill_done, 1'b0);

        // Reset on the request cycle drops mem_request at once.
        bus.req_valid = 1'b1;
        tick(); bus.req_valid = 1'b0;
        chk1("rst_req_pre", bus.mem_request, 1'b1);
        do_reset();
        clean_miss("after_rst");

        // Randomized misses and OCM behaviour.
        dead = 0;
        for (int k = 0; k < 4000; k++) begin
            if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 599) == 0) do_reset();
            bus.req_valid      = ($urandom_range(0, 2) == 0);
            bus.req_fill_addr  = 16'($urandom);
            bus.req_evict      = $urandom_range(0, 1) == 1;
            bus.req_evict_addr = 16'($urandom);
            bus.req_evict_mask = 16'($urandom);
            bus.req_evict_data = {$urandom, $urandom, $urandom, $urandom};
            if (!m_act && !m_err && bus.req_valid) dead = ($urandom_range(0, 9) == 0);
            bus.mem_finish     = !dead && ($urandom_range(0, 3) == 0);
            bus.mem_partial    = ($urandom_range(0, 5) == 0);
            bus.mem_replace    = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_refill_ctrl.md
# dcache_refill_ctrl

Initiator side of the data-path line interface served by the on-chip memory (OCM). It takes one miss at a time from the data cache, optionally writes back a dirty victim line with byte commits, then issues a line read whose completion drives the cache refill through `mem_replace`. It owns the handshake timing, partial-completion retry, timeout retry and error reporting.

## Interface
- `TIMEOUT`, 15: cycles to wait in a WAIT state for `mem_finish` before reissuing (≥2).
- `MAX_RETRY`, 3: reissues allowed per accepted miss; total attempts = MAX_RETRY+1 per phase budget (shared).
- `sys_clk`  in  1  single clock, rising edge.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  miss request from cache.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_fill_addr`  in  16  miss address; bits [3:0] ignored.
- `req_evict`  in  1  victim is dirty, write back first.
- `req_evict_addr`  in  16  victim address; bits [3:0] ignored.
- `req_evict_data`  in  128  victim line.
- `req_evict_mask`  in  16  per-byte commit mask for victim.
- `fill_done`  out  1  one-cycle pulse: refill complete.
- `err`  out  1  sticky: retry budget exhausted.
- `mem_request`  out  1  transaction request, one cycle per attempt.
- `mem_rwn`  out  1  1 = read, 0 = write.
- `mem_addr`  out  16  line address, [3:0] = 0.
- `mem_commit`  out  16  byte enables (write); 0 on read.
- `mem_write_data`  out  128  write line.
- `mem_finish`  in  1  completion from OCM.
- `mem_partial`  in  1  qualifies `mem_finish`: transaction incomplete.
- `mem_replace`  in  1  read completion with refill data to cache.

## Operation
- States: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, DONE, ERR. Moore outputs from state register.
- IDLE: `req_ready`=1. On `req_valid`: latch all req_* fields (addresses with [3:0] cleared), clear retry counter; go WB_REQ if `req_evict` else RD_REQ.
- WB_REQ: `mem_request`=1, `mem_rwn`=0, `mem_addr`=evict addr, `mem_commit`=mask, `mem_write_data`=data. Next WB_WAIT, timer cleared.
- WB_WAIT: `mem_request`=0, mem_* held. `mem_finish`&!`mem_partial` → RD_REQ. `mem_finish`&`mem_partial`, or timer = TIMEOUT-1 without finish → retry.
- RD_REQ: `mem_request`=1, `mem_rwn`=1, `mem_addr`=fill addr, `mem_commit`=0. Next RD_WAIT, timer cleared.
- RD_WAIT: `mem_finish`&!`mem_partial`&`mem_replace` → DONE. Finish with partial, finish without replace, or timeout → retry.
- Retry: if counter < MAX_RETRY, increment, return to the same phase's REQ state; else → ERR.
- DONE: `fill_done`=1, `req_ready`=0; next IDLE.
- ERR: `err`=1, `req_ready`=0, `mem_request`=0; held until reset.
- `mem_finish` outside WAIT states ignored. `mem_finish` on the timeout cycle wins over timeout.
- Timer width ceil(log2(TIMEOUT)); retry counter width ceil(log2(MAX_RETRY+1)); both saturate-free by construction.

## Timing
- Reset (async, immediate): state IDLE, `req_ready`=1, `mem_request`=0, `mem_rwn`=1, `mem_addr`=0, `mem_commit`=0, `mem_write_data`=0, `fill_done`=0, `err`=0, counters 0. Reset mid-transaction drops `mem_request` immediately; no completion reported.
- No evict, OCM finish one cycle after request: accept at cycle 0, `mem_request` cycle 1, `mem_finish`/`mem_replace` cycle 2, `fill_done` cycle 3, `req_ready` cycle 4. Accept-to-done = 3 cycles.
- With evict: write request cycle 1, finish cycle 2, read request cycle 3, finish cycle 4, `fill_done` cycle 5.
- `mem_request` never high two consecutive cycles; mem_addr/rwn/commit/data stable from REQ through end of WAIT.
- Timeout retry: request reissued TIMEOUT+1 cycles after previous request.

## Test plan
- Clean miss, fill_addr 0x1A37: `mem_request` 1 cycle with `mem_addr`=0x1A30, `mem_rwn`=1, `mem_commit`=0; finish+replace next cycle → `fill_done` 3 cycles after accept, `req_ready` back high.
- Dirty miss, evict 0x0455/mask 0x00FF/data D, fill 0x8000: write at 0x0450 commit 0x00FF data D, then read at 0x8000 → `fill_done` at cycle 5.
- `mem_partial`=1 on first write finish → write reissued identically next cycle; second finish clean → read proceeds, `fill_done` at cycle 7.
- `mem_finish` never returned, TIMEOUT=15, MAX_RETRY=3 → 4 requests spaced 16 cycles, then `err`=1, `req_ready`=0; only `sys_rst_n` low clears.
- `mem_finish` on timer = TIMEOUT-1 → accepted, no reissue; stray `mem_finish` in IDLE → no effect.
- `sys_rst_n` low during RD_WAIT → `mem_request`=0, state IDLE, no `fill_done`; new request afterwards completes normally.
